// File: rtl/wb_arith_unit.sv
// Wishbone CSR arithmetic peripheral: ADD, SUB and iterative unsigned MUL
// on two operands, with a start/busy/done handshake and a double-width result.
module wb_arith_unit #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32,
    parameter int GRANULE    = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [ADDR_WIDTH-1:0]         adr_i,
    input  logic [DATA_WIDTH-1:0]         dat_i,
    output logic [DATA_WIDTH-1:0]         dat_o,
    input  logic [DATA_WIDTH/GRANULE-1:0] sel_i,
    input  logic                          we_i,
    input  logic                          stb_i,
    input  logic                          cyc_i,
    output logic                          ack_o,
    output logic                          err_o
);

    localparam int SEL_WIDTH = DATA_WIDTH / GRANULE;
    localparam int DW        = DATA_WIDTH;
    localparam int CW        = $clog2(DATA_WIDTH) + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EXEC = 1'b1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;

    logic [0:0]      r_state;
    logic [DW-1:0]   r_op1;
    logic [DW-1:0]   r_op2;
    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_b;
    logic [1:0]      r_op;
    logic [CW-1:0]   r_cnt;
    logic [2*DW-1:0] r_prod;
    logic [DW-1:0]   r_res_lo;
    logic [DW-1:0]   r_res_hi;
    logic            r_done;
    logic            r_flag;
    logic            r_ack;
    logic            r_err;
    logic [DW-1:0]   r_dat;

    logic            w_acc;
    logic            w_busy;
    logic            w_is_op1;
    logic            w_is_op2;
    logic            w_is_ctrl;
    logic            w_is_stat;
    logic            w_bad_adr;
    logic            w_go;
    logic            w_err;
    logic            w_wr;
    logic            w_start;
    logic            w_clr;
    logic            w_last;
    logic [DW:0]     w_sum;
    logic [DW:0]     w_dif;
    logic [DW:0]     w_madd;
    logic [2*DW-1:0] w_prod_nx;
    logic [DW-1:0]   w_rdata;

    assign w_acc     = cyc_i & stb_i & ~r_ack & ~r_err;
    assign w_busy    = (r_state == S_EXEC);
    assign w_is_op1  = (adr_i == ADDR_WIDTH'(0));
    assign w_is_op2  = (adr_i == ADDR_WIDTH'(1));
    assign w_is_ctrl = (adr_i == ADDR_WIDTH'(2));
    assign w_is_stat = (adr_i == ADDR_WIDTH'(3));
    assign w_bad_adr = (adr_i > ADDR_WIDTH'(5));
    assign w_go      = sel_i[0] & dat_i[0];

    assign w_err = w_bad_adr
                 | (we_i & w_busy & (w_is_op1 | w_is_op2 | w_is_ctrl))
                 | (we_i & w_is_ctrl & w_go & (dat_i[2:1] == 2'b11));

    assign w_wr    = w_acc & we_i & ~w_err;
    assign w_start = w_wr & w_is_ctrl & w_go;
    assign w_clr   = w_wr & w_is_stat & sel_i[0] & dat_i[1];

    assign w_sum = {1'b0, r_a} + {1'b0, r_b};
    assign w_dif = {1'b0, r_a} - {1'b0, r_b};

    // Shift-add step: multiplier sits in the low half and drains out the bottom.
    assign w_madd    = {1'b0, r_prod[2*DW-1:DW]}
                     + (r_prod[0] ? {1'b0, r_a} : {(DW+1){1'b0}});
    assign w_prod_nx = {w_madd, r_prod[DW-1:1]};
    assign w_last    = (r_op != 2'b10) || (r_cnt == CW'(DW - 1));

    always_comb begin
        w_rdata = '0;
        case (adr_i)
            ADDR_WIDTH'(0): w_rdata = r_op1;
            ADDR_WIDTH'(1): w_rdata = r_op2;
            ADDR_WIDTH'(3): w_rdata = DW'({r_flag, r_done, w_busy});
            ADDR_WIDTH'(4): w_rdata = r_res_lo;
            ADDR_WIDTH'(5): w_rdata = r_res_hi;
            default:        w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_op1    <= '0;
            r_op2    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_res_lo <= '0;
            r_res_hi <= '0;
            r_done   <= 1'b0;
            r_flag   <= 1'b0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_dat    <= '0;
        end else begin
            r_ack <= w_acc & ~w_err;
            r_err <= w_acc & w_err;
            if (w_acc) begin
                r_dat <= w_err ? '0 : w_rdata;
            end
            for (int i = 0; i < SEL_WIDTH; i++) begin
                if (w_wr && w_is_op1 && sel_i[i]) begin
                    r_op1[i*GRANULE +: GRANULE] <= dat_i[i*GRANULE +: GRANULE];
                end
                if (w_wr && w_is_op2 && sel_i[i]) begin
                    r_op2[i*GRANULE +: GRANULE] <= dat_i[i*GRANULE +: GRANULE];
                end
            end
            if (w_clr) begin
                r_done <= 1'b0;
            end
            if (w_start) begin
                r_state <= S_EXEC;
                r_a     <= r_op1;
                r_b     <= r_op2;
                r_prod  <= {{DW{1'b0}}, r_op2};
                r_op    <= dat_i[2:1];
                r_cnt   <= '0;
                r_done  <= 1'b0;
                r_flag  <= 1'b0;
            end else if (w_busy) begin
                r_cnt  <= r_cnt + CW'(1);
                r_prod <= w_prod_nx;
                if (w_last) begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                    case (r_op)
                        OP_ADD: begin
                            r_res_lo <= w_sum[DW-1:0];
                            r_res_hi <= {{(DW-1){1'b0}}, w_sum[DW]};
                            r_flag   <= w_sum[DW];
                        end
                        OP_SUB: begin
                            r_res_lo <= w_dif[DW-1:0];
                            r_res_hi <= {DW{w_dif[DW]}};
                            r_flag   <= w_dif[DW];
                        end
                        default: begin
                            r_res_lo <= w_prod_nx[DW-1:0];
                            r_res_hi <= w_prod_nx[2*DW-1:DW];
                            r_flag   <= |w_prod_nx[2*DW-1:DW];
                        end
                    endcase
                end
            end
        end
    end

    assign ack_o = r_ack;
    assign err_o = r_err;
    assign dat_o = r_dat;

endmodule

// File: doc/wb_arith_unit.md
# wb_arith_unit

Parametrised Wishbone-slave arithmetic peripheral, the successor to the single-function memory-mapped adder. It holds two operands, runs ADD, SUB or iterative unsigned MUL under a start/busy/done handshake, and returns a double-width result. It sits on the LiteX Wishbone bus as a word-addressed CSR block and returns err_o for illegal accesses.

## Interface
- ADDR_WIDTH, 3: word address width; must be ≥3.
- DATA_WIDTH, 32: operand and bus width; must be a multiple of GRANULE and ≥8.
- GRANULE, 8: byte-lane size.
- SEL_WIDTH, DATA_WIDTH/GRANULE: localparam.
- clk_i  in  1  single clock; all logic on the rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- adr_i  in  ADDR_WIDTH  word address.
- dat_i  in  DATA_WIDTH  write data.
- dat_o  out  DATA_WIDTH  read data, registered, valid with ack_o.
- sel_i  in  SEL_WIDTH  byte-lane enables.
- we_i  in  1  write enable.
- stb_i, cyc_i  in  1  Wishbone strobe and cycle.
- ack_o  out  1  normal termination, one-cycle pulse.
- err_o  out  1  error termination, one-cycle pulse; never asserted together with ack_o.

## Operation
- Address map (word): 0 OP1 (RW), 1 OP2 (RW), 2 CTRL (W; reads 0), 3 STATUS (R, W1C), 4 RES_LO (R), 5 RES_HI (R), 6–7 and above: invalid.
- OP1/OP2 writes honour sel_i per byte lane. CTRL/STATUS writes use bits [7:0] only and require sel_i[0]; they are ignored otherwise, but still acked.
- CTRL: bit0 START, bits[2:1] OP (00 ADD, 01 SUB, 10 MUL, 11 reserved).
- STATUS: bit0 BUSY, bit1 DONE (sticky; write 1 clears), bit2 FLAG. Other bits read 0.
- FLAG meaning: ADD carry-out; SUB borrow; MUL result upper half nonzero.
- Results:
  - ADD: RES_LO = OP1+OP2 mod 2^DW; RES_HI = {0…, carry}.
  - SUB: RES_LO = OP1−OP2 mod 2^DW; RES_HI = all-ones if borrow, else 0.
  - MUL: {RES_HI, RES_LO} = OP1×OP2 (unsigned, 2·DW bits).
- FSM states:
  - IDLE → EXEC on an accepted CTRL write with START=1 and valid OP. On this transition, latch the operands and OP, clear DONE and FLAG, and set BUSY.
  - EXEC:
    - ADD/SUB: one cycle.
    - MUL: radix-2 shift-add, DATA_WIDTH cycles, iteration counter of $clog2(DATA_WIDTH)+1 bits.
    - On the final EXEC cycle, write the result, set DONE and FLAG, clear BUSY, and return to IDLE.
- err_o cases; no side effects when any of these occurs:
  - invalid address;
  - write to OP1, OP2 or CTRL while BUSY;
  - CTRL write with START=1 and OP=11.
- RES_LO/RES_HI are read-only. A write to them is acked and ignored.
- Reads are side-effect free.

## Timing
- A request is accepted on an edge where cyc_i & stb_i & !ack_o & !err_o. ack_o or err_o goes high for exactly the next cycle, with dat_o valid. Back-to-back requests therefore complete every 2 cycles.
- Register writes and FSM start take effect on the accept edge.
- START accepted at edge T:
  - BUSY reads 1 from T+1.
  - ADD/SUB: result and DONE are visible at T+2.
  - MUL: result and DONE are visible at T+1+DATA_WIDTH.
- A STATUS read accepted on the same edge as DONE being set returns the pre-edge value.
- A W1C of DONE on the same edge as DONE being set: the set wins.
- cyc_i dropping after accept does not cancel the response pulse or the write side effects.
- Reset values (rst_ni low at an edge, any state, including mid-MUL):
  - ack_o=0, err_o=0, dat_o=0;
  - all registers 0;
  - FSM IDLE;
  - any pending response is dropped.

## Test plan
- Reset, then read all 6 registers → all return 0 with ack_o. Read address 6 → err_o=1, ack_o=0, dat_o=0.
- ADD:
  - OP1=0xFFFFFFFF, OP2=0x00000002, CTRL=0x1.
  - Poll STATUS → 0x6 (DONE|FLAG) by T+2.
  - RES_LO=0x00000001, RES_HI=0x00000001.
- SUB:
  - OP1=3, OP2=5, CTRL=0x3.
  - RES_LO=0xFFFFFFFE, RES_HI=0xFFFFFFFF, STATUS=0x6.
- MUL, with DATA_WIDTH=32:
  - OP1=0xFFFFFFFF, OP2=0xFFFFFFFF, CTRL=0x5.
  - BUSY stays set for 32 cycles.
  - OP1 write during BUSY → err_o and OP1 unchanged.
  - Final result RES_HI=0xFFFFFFFE, RES_LO=0x00000001, FLAG=1.
- CTRL=0x7 → err_o, BUSY stays 0. Write STATUS=0x2 after a done op → DONE clears, FLAG kept. Byte write OP1 with sel_i=0b0010, dat_i=0x0000AB00 → OP1=0x0000AB00 from 0.
- Start a MUL, then assert rst_ni=0 for one cycle at iteration 10 → all registers 0, STATUS=0. A new ADD 1+1 then gives RES_LO=2.
